jtag_shift_ctrl: RTL
====================

Name: jtag_shift_ctrl

Overview:
- Clocked JTAG master sequencer for a single target TAP controller.
- Generates TCK, TMS and TDI to walk the TAP from Run-Test/Idle into Shift-IR or Shift-DR, shifts up to MAX_BITS bits LSB-first, captures TDO, and returns to Run-Test/Idle.
- Sits between the host register interface (start/done handshake) and the JTAG pins.

Parameters:
- MAX_BITS, 32, width of the shift data vectors and the maximum bits shifted per scan.
- LEN_W, 6, width of the len port; must satisfy 2^LEN_W > MAX_BITS.
- TCK_DIV, 2, clk cycles per TCK half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  scan request; sampled only while busy=0.
- ir_sel  in  1  1 = IR scan, 0 = DR scan; captured with start.
- len  in  LEN_W  number of bits to shift; captured with start.
- tdi_data  in  MAX_BITS  data shifted out; bit 0 first; captured with start.
- busy  out  1  high while a reset sequence or scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- tdo_data  out  MAX_BITS  captured TDO bits; bit 0 is the first captured bit; held until the next completed scan.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: tck=0, tms=1, tdi=0, busy=1, done=0, tdo_data=0.
  - The controller enters RST_SEQ. Reset mid-scan aborts the scan; no done pulse is generated for it.
- TCK generation:
  - One TCK period is 2*TCK_DIV clk cycles: tck low for TCK_DIV cycles, then high for TCK_DIV cycles.
  - tck toggles only in states other than IDLE. In IDLE, tck is held at 0.
  - tms and tdi update only on the clk edge where tck goes 1->0, or on entry to the first period.
  - tdo is sampled on the clk edge where tck goes 0->1.
- Controller states:
  - RST_SEQ: 6 TCK periods with TMS = 1,1,1,1,1,0, which leaves the TAP in Run-Test/Idle. Then go to IDLE and set busy=0.
  - IDLE: tms=0, tdi=0. When start=1, capture ir_sel, len and tdi_data, set busy=1 on the next cycle, and go to NAV.
  - NAV: drive the TMS sequence 1,0,0 for DR or 1,1,0,0 for IR, one bit per TCK period. This ends in Shift-DR or Shift-IR. Then go to SHIFT.
  - SHIFT: N = min(len, MAX_BITS) TCK periods. Period i drives tdi = tdi_data[i] and captures tdo into bit i of a shadow register. tms=0 for the first N-1 periods and tms=1 on the last period (the TAP moves to Exit1). Then go to EXIT.
  - EXIT: TMS 1 (Update), then TMS 0 (Run-Test/Idle). Then go to DONE.
  - DONE: copy the shadow register to tdo_data, with bits >= N forced to 0. Pulse done=1 for one cycle, set busy=0, and return to IDLE.
- Total TCK periods per scan: DR = N+5, IR = N+6. The done pulse occurs 1 clk after the final tck falling-edge period ends.
- Boundary conditions:
  - len=0: no TCK activity; done pulses on the clk cycle after start; tdo_data is unchanged.
  - len > MAX_BITS: clamped to MAX_BITS.
  - start while busy=1 is ignored and not queued.
  - start on the same cycle as done: ignored, because busy is still 1 in that cycle.

Optional Feature:
- Macro: JTAG_TAP_MON_EN.
- When defined: adds output tap_state[3:0], which tracks the target TAP state from the TMS values issued on each tck rising edge. Encoding uses the IEEE 1149.1 codes:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
  - Reset value is F.
- When not defined: the port and the tracking logic are absent. The scan behaviour is identical in both cases.

Test Plan:
- Release rst_n with TCK_DIV=2 -> 6 tck rising edges with TMS 1,1,1,1,1,0; busy falls 24 clk after release; tap_state=C.
- DR scan, len=8, tdi_data=0xA5, tdo looped back from tdi -> TMS per period 1,0,0,0,0,0,0,0,0,0,1,1,0 (13 periods); tdi bits 1,0,1,0,0,1,0,1; tdo_data=0x000000A5; one done pulse.
- IR scan, len=5, tdi_data=0x1F, tdo tied 0 -> 11 TCK periods with TMS 1,1,0,0,0,0,0,0,1,1,0; tap_state passes through A; tdo_data=0.
- start pulsed mid-scan with different len/data -> ignored; the first scan completes unchanged; exactly one done pulse.
- len=0 then len=40 (MAX_BITS=32) -> first: done the next cycle with tck static; second: 32 shift periods, 37 total TCK periods.
- rst_n asserted during SHIFT -> outputs take reset values the next cycle; no done pulse; RST_SEQ reruns and the next scan succeeds.

Source files
------------

// File: rtl/jtag_shift_ctrl.sv
// jtag_shift_ctrl: JTAG master sequencer for a single target TAP.
// Walks the TAP from Run-Test/Idle into Shift-IR or Shift-DR. It then shifts
// up to MAX_BITS bits LSB-first, captures TDO, and returns to Run-Test/Idle.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   start, ir_sel, len  scan request (sampled only while busy=0), IR/DR select, bit count
//   tdi_data            bits to shift out, bit 0 first
//   busy, done          in-progress flag, one-cycle completion pulse
//   tdo_data            captured TDO bits, bit 0 = first captured
//   tck, tms, tdi, tdo  JTAG pins
//   tap_state           (only with JTAG_TAP_MON_EN) tracked target TAP state, IEEE 1149.1 codes
//
// Optional feature macro: JTAG_TAP_MON_EN
module jtag_shift_ctrl #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 6,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ir_sel,
  input  logic [LEN_W-1:0]    len,
  input  logic [MAX_BITS-1:0] tdi_data,
  output logic                busy,
  output logic                done,
  output logic [MAX_BITS-1:0] tdo_data,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
`ifdef JTAG_TAP_MON_EN
  ,
  output logic [3:0]          tap_state
`endif
);

  localparam int DIV_W = $clog2(2*TCK_DIV);
  localparam logic [DIV_W-1:0]    DIV_END  = DIV_W'(2*TCK_DIV-1);
  localparam logic [DIV_W-1:0]    DIV_RISE = DIV_W'(TCK_DIV-1);
  localparam logic [DIV_W-1:0]    DIV_HI   = DIV_W'(TCK_DIV);
  localparam logic [MAX_BITS-1:0] ONE      = MAX_BITS'(1);

  typedef enum logic [2:0] {S_RST, S_IDLE, S_NAV, S_SHIFT, S_EXIT, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0]    r_div;
  logic                r_ir, r_tms, r_tdi, w_tms_nxt, w_tdi_nxt;
  logic [LEN_W-1:0]    r_n, w_len_clamp, w_nav_last;
  logic [MAX_BITS-1:0] r_data, r_shadow, r_tdo_data, w_mask, w_shift_src;
  logic                w_run, w_per_end, w_rise;

  // TCK runs only in the states that walk the TAP
  assign w_run     = (r_state == S_RST) || (r_state == S_NAV) ||
                     (r_state == S_SHIFT) || (r_state == S_EXIT);
  assign w_per_end = w_run && (r_div == DIV_END);   // edge where tck falls
  assign w_rise    = w_run && (r_div == DIV_RISE);  // edge where tck rises
  assign w_len_clamp = (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
  assign w_nav_last  = r_ir ? LEN_W'(3) : LEN_W'(2);

  assign tck      = w_run && (r_div >= DIV_HI);
  assign tms      = r_tms;
  assign tdi      = r_tdi;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign tdo_data = r_tdo_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RST:   if (w_per_end) begin
                 if (r_cnt == LEN_W'(5)) begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
                 else w_cnt_nxt = r_cnt + LEN_W'(1);
               end
      S_IDLE:  if (start) begin
                 w_state_nxt = (len == '0) ? S_DONE : S_NAV;
                 w_cnt_nxt   = '0;
               end
      S_NAV:   if (w_per_end) begin
                 if (r_cnt == w_nav_last) begin w_state_nxt = S_SHIFT; w_cnt_nxt = '0; end
                 else w_cnt_nxt = r_cnt + LEN_W'(1);
               end
      S_SHIFT: if (w_per_end) begin
                 if (r_cnt == r_n - LEN_W'(1)) begin w_state_nxt = S_EXIT; w_cnt_nxt = '0; end
                 else w_cnt_nxt = r_cnt + LEN_W'(1);
               end
      S_EXIT:  if (w_per_end) begin
                 if (r_cnt == LEN_W'(1)) begin w_state_nxt = S_DONE; w_cnt_nxt = '0; end
                 else w_cnt_nxt = r_cnt + LEN_W'(1);
               end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_RST;
    endcase
  end

  // Pin values for the period about to start. (state, cnt) only move on a
  // tck falling edge or on scan entry, so registering these every cycle
  // still changes tms/tdi only at those points.
  assign w_shift_src = r_data >> w_cnt_nxt;
  always_comb begin
    w_tms_nxt = 1'b0;
    w_tdi_nxt = 1'b0;
    case (w_state_nxt)
      S_RST:   w_tms_nxt = (w_cnt_nxt != LEN_W'(5));
      S_NAV:   w_tms_nxt = r_ir ? (w_cnt_nxt <= LEN_W'(1)) : (w_cnt_nxt == '0);
      S_SHIFT: begin
                 w_tms_nxt = (w_cnt_nxt == r_n - LEN_W'(1));
                 w_tdi_nxt = w_shift_src[0];
               end
      S_EXIT:  w_tms_nxt = (w_cnt_nxt == '0);
      default: ;
    endcase
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_BITS; i++) w_mask[i] = (i < int'(r_n));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RST;
      r_cnt      <= '0;
      r_div      <= '0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
      r_ir       <= 1'b0;
      r_n        <= '0;
      r_data     <= '0;
      r_shadow   <= '0;
      r_tdo_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= (w_run && !w_per_end) ? r_div + DIV_W'(1) : '0;
      r_tms   <= w_tms_nxt;
      r_tdi   <= w_tdi_nxt;
      if (r_state == S_IDLE && start) begin
        r_ir     <= ir_sel;
        r_n      <= w_len_clamp;
        r_data   <= tdi_data;
        r_shadow <= '0;
      end
      if (r_state == S_SHIFT && w_rise)
        r_shadow <= (r_shadow & ~(ONE << r_cnt)) | (MAX_BITS'(tdo) << r_cnt);
      // a zero-length scan leaves the previous result in place
      if (r_state == S_DONE && r_n != '0)
        r_tdo_data <= r_shadow & w_mask;
    end
  end

`ifdef JTAG_TAP_MON_EN
  logic [3:0] r_tap;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      4'hF: return m ? 4'hF : 4'hC;
      4'hC: return m ? 4'h7 : 4'hC;
      4'h7: return m ? 4'h4 : 4'h6;
      4'h6: return m ? 4'h1 : 4'h2;
      4'h2: return m ? 4'h1 : 4'h2;
      4'h1: return m ? 4'h5 : 4'h3;
      4'h3: return m ? 4'h0 : 4'h3;
      4'h0: return m ? 4'h5 : 4'h2;
      4'h5: return m ? 4'h7 : 4'hC;
      4'h4: return m ? 4'hF : 4'hE;
      4'hE: return m ? 4'h9 : 4'hA;
      4'hA: return m ? 4'h9 : 4'hA;
      4'h9: return m ? 4'hD : 4'hB;
      4'hB: return m ? 4'h8 : 4'hB;
      4'h8: return m ? 4'hD : 4'hA;
      default: return m ? 4'h7 : 4'hC;  // UpdIR (D)
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n)      r_tap <= 4'hF;
    else if (w_rise) r_tap <= tap_next(r_tap, r_tms);
  end
  assign tap_state = r_tap;
`endif

endmodule
